// File: rtl/disp_pkg.sv
// disp_pkg: constants shared by the display scan and related timing blocks.
package disp_pkg;
  localparam int PRESCALE_1KHZ_AT_100MHZ = 100000;
  localparam logic SCAN_UP = 1'b0;
  localparam logic SCAN_DOWN = 1'b1;
  localparam logic [63:0] AN_OFF = '1;
endpackage

// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_ctrl_if: control inputs and anode/index outputs of the digit scanner.
interface digit_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DUTY_W = 4
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  logic en;
  logic dir;
  logic [NUM_DIGITS-1:0] blank;
  logic [DUTY_W-1:0] bright;
  logic [NUM_DIGITS-1:0] an;
  logic [IDX_W-1:0] dig_idx;
  logic tick;
  logic wrap;
  modport master (output en, dir, blank, bright, input an, dig_idx, tick, wrap);
  modport slave (input en, dir, blank, bright, output an, dig_idx, tick, wrap);
endinterface

// File: rtl/digit_scan_ctrl_tick_gen.sv
// tick_gen: enable-gated prescaler; step strobes on the last count, tick is its registered copy.
module tick_gen #(
  parameter int PRESCALE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic step,
  output logic tick
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d;
  always_comb begin
    step = en && (cnt_q == CW'(PRESCALE - 1));
    cnt_d = step ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    tick_d = step;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick_q <= tick_d;
    end
  assign tick = tick_q;
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed display scanner with prescaler, PWM brightness, blanking and direction.
module digit_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE = PRESCALE_1KHZ_AT_100MHZ,
  parameter int DUTY_W = 4
) (
  input logic clk,
  input logic rst_n,
  digit_scan_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  logic step, phase_wrap, lit;
  logic [DUTY_W-1:0] phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc, idx_dec;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic wrap_q, wrap_d;
  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk(clk),
    .rst_n(rst_n),
    .en(bus.en),
    .step(step),
    .tick(bus.tick)
  );
  always_comb begin
    phase_wrap = step && (phase_q == '1);
    idx_inc = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    idx_dec = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
    phase_d = step ? phase_q + 1'b1 : phase_q;
    idx_d = phase_wrap ? ((bus.dir == SCAN_DOWN) ? idx_dec : idx_inc) : idx_q;
    wrap_d = phase_wrap && ((bus.dir == SCAN_DOWN) ? (idx_q == '0) : (idx_q == IDX_LAST));
    // AN reflects the slot state as it stood before this edge, so it trails DIG_IDX by one cycle
    lit = bus.en && !bus.blank[idx_q] && (phase_q <= bus.bright);
    an_d = lit ? ~(NUM_DIGITS'(1) << idx_q) : AN_OFF[NUM_DIGITS-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase_q <= '0;
      idx_q <= '0;
      an_q <= AN_OFF[NUM_DIGITS-1:0];
      wrap_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      idx_q <= idx_d;
      an_q <= an_d;
      wrap_q <= wrap_d;
    end
  assign bus.an = an_q;
  assign bus.dig_idx = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: randomized bench comparing a 3-digit/PRESCALE=2 and a 5-digit/PRESCALE=1 scanner to a count-based model.
module tb_digit_scan_ctrl;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  digit_scan_ctrl_if #(.NUM_DIGITS(3), .DUTY_W(2)) a_if ();
  digit_scan_ctrl_if #(.NUM_DIGITS(5), .DUTY_W(2)) b_if ();
  digit_scan_ctrl #(.NUM_DIGITS(3), .PRESCALE(2), .DUTY_W(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  digit_scan_ctrl #(.NUM_DIGITS(5), .PRESCALE(1), .DUTY_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  int nd[2] = '{3, 5};
  int ps[2] = '{2, 1};
  int n_en[2], sub[2], idx[2], e_an[2], e_tick[2], e_wrap[2];
  int vectors = 0;
  int miscompares = 0;
  logic en_v = 1'b0, dir_v = 1'b0;
  logic [7:0] bl_a = '0, bl_b = '0;
  int br_v = 0;
  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      n_en[d] = 0; sub[d] = 0; idx[d] = 0;
      e_an[d] = (1 << nd[d]) - 1; e_tick[d] = 0; e_wrap[d] = 0;
    end
  endtask
  // Enabled-cycle and sub-tick counts drive everything: a sub-tick every ps cycles, a slot every S sub-ticks
  task automatic model_edge(input int d, input logic [7:0] blank);
    int all;
    all = (1 << nd[d]) - 1;
    e_an[d] = (en_v && !blank[idx[d]] && (sub[d] % S) <= br_v) ? (all & ~(1 << idx[d])) : all;
    e_tick[d] = 0;
    e_wrap[d] = 0;
    if (en_v) begin
      n_en[d]++;
      if (n_en[d] % ps[d] == 0) begin
        e_tick[d] = 1;
        sub[d]++;
        if (sub[d] % S == 0) begin
          if (dir_v) begin
            e_wrap[d] = (idx[d] == 0);
            idx[d] = (idx[d] + nd[d] - 1) % nd[d];
          end else begin
            e_wrap[d] = (idx[d] == nd[d] - 1);
            idx[d] = (idx[d] + 1) % nd[d];
          end
        end
      end
    end
  endtask
  task automatic check_all();
    int zeros;
    check("a.an", int'(a_if.an), e_an[0]);
    check("a.idx", int'(a_if.dig_idx), idx[0]);
    check("a.tick", int'(a_if.tick), e_tick[0]);
    check("a.wrap", int'(a_if.wrap), e_wrap[0]);
    check("b.an", int'(b_if.an), e_an[1]);
    check("b.idx", int'(b_if.dig_idx), idx[1]);
    check("b.tick", int'(b_if.tick), e_tick[1]);
    check("b.wrap", int'(b_if.wrap), e_wrap[1]);
    zeros = 0;
    for (int i = 0; i < 3; i++) zeros += int'(!a_if.an[i]);
    check("a.an_onehot", int'(zeros <= 1), 1);
  endtask
  task automatic drive();
    a_if.en = en_v; b_if.en = en_v;
    a_if.dir = dir_v; b_if.dir = dir_v;
    a_if.blank = bl_a[2:0]; b_if.blank = bl_b[4:0];
    a_if.bright = 2'(br_v); b_if.bright = 2'(br_v);
  endtask
  task automatic cycle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge(0, bl_a);
      model_edge(1, bl_b);
      #1 check_all();
    end
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    #1 rst_n = 1'b1;
  endtask
  initial begin
    drive();
    model_reset();
    #12 check_all();
    rst_n = 1'b1;
    en_v = 1'b1; bl_a = '0; bl_b = '0; br_v = 3;
    drive();
    cycle(50);
    dir_v = 1'b1; drive(); cycle(20);
    dir_v = 1'b0; drive(); cycle(3);
    dir_v = 1'b1; drive(); cycle(30);
    br_v = 0; drive(); cycle(24);
    br_v = 1; drive(); cycle(24);
    br_v = 3; dir_v = 1'b0; bl_a = 8'b010; bl_b = 8'b01010; drive(); cycle(30);
    bl_a = '0; bl_b = '0; drive(); cycle(5);
    en_v = 1'b0; drive(); cycle(10);
    en_v = 1'b1; drive(); cycle(20);
    async_reset();
    cycle(30);
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(15) == 0) en_v = ~en_v;
      if ($urandom_range(31) == 0) dir_v = ~dir_v;
      if ($urandom_range(19) == 0) br_v = $urandom_range(3);
      if ($urandom_range(39) == 0) begin
        bl_a = 8'($urandom_range(7));
        bl_b = 8'($urandom_range(31));
      end
      drive();
      cycle(1);
      if ($urandom_range(299) == 0) async_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
